uart_rx_buffered: RTL and testbench

//  Receive end of the UART link driven by UART_TX: deserialises 8N1 frames from the

---
 rtl/uart_rx_buffered.sv | 206 ++++++++++++++++++++
 tb/tb_uart_rx_buffered.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_buffered.sv
// UART receiver with start-glitch rejection, framing/overrun flags and a first-word-fall-through byte FIFO.
// The frame is 8N1 by default. Define UART_RX_PARITY_EN to receive 8E1 frames and enable o_Parity_Err.
module uart_rx_buffered #(
    parameter int CLKS_PER_BIT = 217,
    parameter int FIFO_DEPTH   = 8,
    parameter int FIFO_AW      = 3
) (
    input  logic             i_Clock,
    input  logic             i_Reset,
    input  logic             i_RX_Serial,
    input  logic             i_Rd_En,
    output logic [7:0]       o_Rd_Byte,
    output logic             o_Empty,
    output logic             o_Full,
    output logic [FIFO_AW:0] o_Count,
    output logic             o_RX_Active,
    output logic             o_Frame_Err,
    output logic             o_Parity_Err,
    output logic             o_Overrun
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CNT_W-1:0]   HALF_BIT  = CNT_W'(CLKS_PER_BIT / 2);
    localparam logic [CNT_W-1:0]   LAST_CLK  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [FIFO_AW:0]   DEPTH_VAL = (FIFO_AW+1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_WAIT_HIGH
`ifdef UART_RX_PARITY_EN
        , S_PARITY
`endif
    } state_t;

    state_t           state, state_next;
    logic [CNT_W-1:0] clk_cnt, clk_cnt_next;
    logic [2:0]       bit_idx, bit_idx_next;
    logic [7:0]       shift, shift_next;
    logic             rx_meta, rx_sync;
    logic             byte_done;
    logic             frame_err;
`ifdef UART_RX_PARITY_EN
    logic             parity_bit, parity_bit_next;
    logic             parity_err;
`endif

    // The synchroniser resets to the idle line level, so reset can never look like a start bit.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= i_RX_Serial;
            rx_sync <= rx_meta;
        end
    end

    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            state   <= S_IDLE;
            clk_cnt <= '0;
            bit_idx <= '0;
            shift   <= '0;
`ifdef UART_RX_PARITY_EN
            parity_bit <= 1'b0;
`endif
        end else begin
            state   <= state_next;
            clk_cnt <= clk_cnt_next;
            bit_idx <= bit_idx_next;
            shift   <= shift_next;
`ifdef UART_RX_PARITY_EN
            parity_bit <= parity_bit_next;
`endif
        end
    end

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        state_next   = state;
        clk_cnt_next = clk_cnt;
        bit_idx_next = bit_idx;
        shift_next   = shift;
        byte_done    = 1'b0;
        frame_err    = 1'b0;
`ifdef UART_RX_PARITY_EN
        parity_bit_next = parity_bit;
        parity_err      = 1'b0;
`endif
        case (state)
            S_IDLE: begin
                if (!rx_sync) begin
                    state_next   = S_START;
                    clk_cnt_next = '0;
                end
            end
            S_START: begin
                if (clk_cnt == HALF_BIT) begin
                    clk_cnt_next = '0;
                    bit_idx_next = '0;
                    state_next   = rx_sync ? S_IDLE : S_DATA;
                end else begin
                    clk_cnt_next = clk_cnt + 1'b1;
                end
            end
            S_DATA: begin
                if (clk_cnt == LAST_CLK) begin
                    clk_cnt_next = '0;
                    shift_next   = {rx_sync, shift[7:1]};
                    bit_idx_next = bit_idx + 1'b1;
                    if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_next = S_PARITY;
`else
                        state_next = S_STOP;
`endif
                    end
                end else begin
                    clk_cnt_next = clk_cnt + 1'b1;
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (clk_cnt == LAST_CLK) begin
                    clk_cnt_next    = '0;
                    parity_bit_next = rx_sync;
                    state_next      = S_STOP;
                end else begin
                    clk_cnt_next = clk_cnt + 1'b1;
                end
            end
`endif
            S_STOP: begin
                if (clk_cnt == LAST_CLK) begin
                    clk_cnt_next = '0;
                    if (rx_sync) begin
                        state_next = S_IDLE;
`ifdef UART_RX_PARITY_EN
                        if (^{shift, parity_bit}) parity_err = 1'b1;
                        else                      byte_done  = 1'b1;
`else
                        byte_done = 1'b1;
`endif
                    end else begin
                        // A low stop bit may be a break; wait for the line to return high.
                        frame_err  = 1'b1;
                        state_next = S_WAIT_HIGH;
                    end
                end else begin
                    clk_cnt_next = clk_cnt + 1'b1;
                end
            end
            S_WAIT_HIGH: begin
                if (rx_sync) state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    assign o_RX_Active = (state != S_IDLE) && (state != S_WAIT_HIGH);
    assign o_Frame_Err = frame_err;
`ifdef UART_RX_PARITY_EN
    assign o_Parity_Err = parity_err;
`else
    assign o_Parity_Err = 1'b0;
`endif

    logic [7:0]         mem [FIFO_DEPTH];
    logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
    logic [FIFO_AW:0]   count;
    logic               do_push, do_pop;

    assign o_Empty   = (count == '0);
    assign o_Full    = (count == DEPTH_VAL);
    assign o_Count   = count;
    assign do_pop    = i_Rd_En && !o_Empty;
    assign do_push   = byte_done && (!o_Full || do_pop);
    assign o_Overrun = byte_done && o_Full && !do_pop;
    assign o_Rd_Byte = o_Empty ? 8'h00 : mem[rd_ptr];

    // NOTE: the storage array has no reset; o_Rd_Byte is masked while empty, so stale entries are never visible.
    always_ff @(posedge i_Clock) begin
        if (do_push) mem[wr_ptr] <= shift;
    end

    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_buffered.sv
// Directed self-checking bench for uart_rx_buffered at 217 clocks per bit and a 40 ns clock.
// Inputs change 2 ns after a rising edge, and outputs are sampled on the falling edge.
module tb_uart_rx_buffered;

    localparam int CLKS_PER_BIT = 217;
    localparam int FIFO_AW      = 3;

    logic             i_Clock = 1'b0;
    logic             i_Reset = 1'b1;
    logic             i_RX_Serial = 1'b1;
    logic             i_Rd_En = 1'b0;
    logic [7:0]       o_Rd_Byte;
    logic             o_Empty, o_Full, o_RX_Active;
    logic             o_Frame_Err, o_Parity_Err, o_Overrun;
    logic [FIFO_AW:0] o_Count;

    int n_checks = 0;
    int n_pass   = 0;
    int frame_err_seen  = 0;
    int parity_err_seen = 0;
    int overrun_seen    = 0;

    uart_rx_buffered #(.CLKS_PER_BIT(CLKS_PER_BIT), .FIFO_DEPTH(8), .FIFO_AW(FIFO_AW)) dut (
        .i_Clock      (i_Clock),
        .i_Reset      (i_Reset),
        .i_RX_Serial  (i_RX_Serial),
        .i_Rd_En      (i_Rd_En),
        .o_Rd_Byte    (o_Rd_Byte),
        .o_Empty      (o_Empty),
        .o_Full       (o_Full),
        .o_Count      (o_Count),
        .o_RX_Active  (o_RX_Active),
        .o_Frame_Err  (o_Frame_Err),
        .o_Parity_Err (o_Parity_Err),
        .o_Overrun    (o_Overrun)
    );

    always #20 i_Clock = ~i_Clock;

    always @(negedge i_Clock) begin
        if (o_Frame_Err)  frame_err_seen++;
        if (o_Parity_Err) parity_err_seen++;
        if (o_Overrun)    overrun_seen++;
    end

    initial begin
        #(40 * 90000);
        $display("FAIL watchdog: simulation still running after 90000 cycles");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic drive_bit(input logic b);
        @(posedge i_Clock);
        #2 i_RX_Serial = b;
        repeat (CLKS_PER_BIT - 1) @(posedge i_Clock);
    endtask

    task automatic send_frame(input logic [7:0] data, input logic stop_bit, input logic par_bit);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(data[i]);
`ifdef UART_RX_PARITY_EN
        drive_bit(par_bit);
`endif
        drive_bit(stop_bit);
    endtask

    task automatic send_byte(input logic [7:0] data);
        send_frame(data, 1'b1, ^data);
        drive_bit(1'b1);
    endtask

    task automatic pop_check(input string tag, input logic [7:0] exp);
        @(negedge i_Clock);
        check(tag, o_Rd_Byte, exp);
        @(posedge i_Clock);
        #2 i_Rd_En = 1'b1;
        @(posedge i_Clock);
        #2 i_Rd_En = 1'b0;
    endtask

    initial begin
        int fe0, ov0;
        logic early;
        logic fell;

        // Reset state.
        repeat (3) @(posedge i_Clock);
        @(negedge i_Clock);
        check("rst_empty",   o_Empty, 1);
        check("rst_full",    o_Full, 0);
        check("rst_count",   o_Count, 0);
        check("rst_rd_byte", o_Rd_Byte, 8'h00);
        check("rst_active",  o_RX_Active, 0);
        check("rst_errs",    {o_Frame_Err, o_Parity_Err, o_Overrun}, 0);
        @(posedge i_Clock);
        #2 i_Reset = 1'b0;
        repeat (4) @(posedge i_Clock);

        // 1. A single frame. o_Empty must fall on the same edge on which o_RX_Active falls.
        early = 1'b0;
        fell  = 1'b0;
        fork
            send_byte(8'hAB);
            begin
                for (int i = 0; i < 20 && !o_RX_Active; i++) @(negedge i_Clock);
                check("t1_active_rise", o_RX_Active, 1);
                for (int i = 0; i < 3000; i++) begin
                    @(negedge i_Clock);
                    if (!o_RX_Active) begin
                        fell = 1'b1;
                        break;
                    end
                    if (!o_Empty) early = 1'b1;
                end
                check("t1_active_fell", fell, 1);
                check("t1_empty_while_active", early, 0);
                check("t1_empty_at_stop", o_Empty, 0);
                check("t1_count", o_Count, 1);
            end
        join
        pop_check("t1_byte", 8'hAB);
        @(negedge i_Clock);
        check("t1_empty_after_pop", o_Empty, 1);

        // 2. A low glitch shorter than half a bit is rejected.
        fe0 = frame_err_seen;
        @(posedge i_Clock);
        #2 i_RX_Serial = 1'b0;
        repeat (50) @(posedge i_Clock);
        @(negedge i_Clock);
        check("t2_active_during", o_RX_Active, 1);
        @(posedge i_Clock);
        #2 i_RX_Serial = 1'b1;
        repeat (150) @(posedge i_Clock);
        @(negedge i_Clock);
        check("t2_active_after", o_RX_Active, 0);
        check("t2_empty", o_Empty, 1);
        check("t2_no_frame_err", frame_err_seen - fe0, 0);

        // 3. A low stop bit and a break are followed by a good frame.
        fe0 = frame_err_seen;
        send_frame(8'h55, 1'b0, ^8'h55);
        repeat (5 * CLKS_PER_BIT) @(posedge i_Clock);
        @(negedge i_Clock);
        check("t3_frame_err_pulses", frame_err_seen - fe0, 1);
        check("t3_count", o_Count, 0);
        check("t3_active_in_break", o_RX_Active, 0);
        drive_bit(1'b1);
        send_byte(8'h3C);
        @(negedge i_Clock);
        check("t3_count_after", o_Count, 1);
        pop_check("t3_byte", 8'h3C);

        // 4. Fill the FIFO, then overrun it with a ninth byte.
        ov0 = overrun_seen;
        for (int b = 0; b < 8; b++) send_byte(8'(b));
        @(negedge i_Clock);
        check("t4_full", o_Full, 1);
        check("t4_count_full", o_Count, 8);
        check("t4_no_overrun_yet", overrun_seen - ov0, 0);
        send_byte(8'h08);
        @(negedge i_Clock);
        check("t4_overrun", overrun_seen - ov0, 1);
        check("t4_count_after_ovr", o_Count, 8);
        for (int b = 0; b < 8; b++) pop_check($sformatf("t4_byte%0d", b), 8'(b));
        @(negedge i_Clock);
        check("t4_empty", o_Empty, 1);

        // 5. Reset arrives in the middle of data bit 3 of 0x9A.
        drive_bit(1'b0);
        for (int i = 0; i < 3; i++) drive_bit(1'((8'h9A >> i) & 8'h01));
        @(posedge i_Clock);
        #2 i_RX_Serial = 1'b1;
        repeat (100) @(posedge i_Clock);
        #2 i_Reset = 1'b1;
        repeat (3) @(posedge i_Clock);
        #2 i_Reset = 1'b0;
        @(negedge i_Clock);
        check("t5_empty", o_Empty, 1);
        check("t5_count", o_Count, 0);
        check("t5_active", o_RX_Active, 0);
        drive_bit(1'b1);
        send_byte(8'hC3);
        @(negedge i_Clock);
        check("t5_count_after", o_Count, 1);
        pop_check("t5_byte", 8'hC3);

`ifdef UART_RX_PARITY_EN
        // 6. Even parity: 0xAB has five ones, so the correct parity bit is 1.
        fe0 = parity_err_seen;
        send_frame(8'hAB, 1'b1, 1'b1);
        drive_bit(1'b1);
        @(negedge i_Clock);
        check("t6_good_count", o_Count, 1);
        check("t6_good_no_perr", parity_err_seen - fe0, 0);
        pop_check("t6_good_byte", 8'hAB);
        send_frame(8'hAB, 1'b1, 1'b0);
        drive_bit(1'b1);
        @(negedge i_Clock);
        check("t6_bad_perr", parity_err_seen - fe0, 1);
        check("t6_bad_count", o_Count, 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
